// File: rtl/uart_rx_pkt_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_pkt_ctrl_if
// Read-side handshake between the UART packet controller and its consumer.
//
// Signals:
//   pkt_valid  checked packet is held; rd_data is valid
//   pkt_len    payload length of the held packet
//   rd_data    payload byte at the current read index
//   rd_last    rd_data is the final payload byte
//   rd_en      consumer accepts rd_data this cycle
//
// Modports:
//   master  packet controller side (drives the packet, samples rd_en)
//   slave   consumer side (samples the packet, drives rd_en)
// -----------------------------------------------------------------------------
interface uart_rx_pkt_ctrl_if;

  logic       pkt_valid;
  logic [7:0] pkt_len;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_en;

  modport master (
    output pkt_valid,
    output pkt_len,
    output rd_data,
    output rd_last,
    input  rd_en
  );

  modport slave (
    input  pkt_valid,
    input  pkt_len,
    input  rd_data,
    input  rd_last,
    output rd_en
  );

endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_pkt_ctrl
// Packet controller behind a UART receiver. Frames look like
//   SYNC LEN PAYLOAD[0..LEN-1] CHK
// where CHK is the XOR of LEN and every payload byte. Good packets are held in
// an internal buffer and read out through a valid/rd_en handshake; malformed
// frames raise one-cycle error pulses and are discarded.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   s_tick        16x baud sample tick, drives the inter-byte timeout
//   rx_done_tick  one-cycle strobe, rx_data valid
//   rx_data       received byte
//   rd            read handshake (pkt_valid, pkt_len, rd_data, rd_last, rd_en)
//   err_len       pulse: LEN == 0 or LEN > MAX_LEN
//   err_chk       pulse: checksum mismatch
//   err_timeout   pulse: no byte for TIMEOUT_TICKS s_ticks mid-frame
//   drop_cnt      saturating count of bytes dropped while a packet is held
// -----------------------------------------------------------------------------
module uart_rx_pkt_ctrl #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_TICKS = 320
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_tick,
  input  logic                       rx_done_tick,
  input  logic [7:0]                 rx_data,
  uart_rx_pkt_ctrl_if.master         rd,
  output logic                       err_len,
  output logic                       err_chk,
  output logic                       err_timeout,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [7:0]      MaxLenB = 8'(MAX_LEN);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    StHunt,
    StLen,
    StPayload,
    StChk,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic [7:0]      len_q, len_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      wr_idx_q, wr_idx_d;
  logic [7:0]      rd_idx_q, rd_idx_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic       pkt_valid_q, pkt_valid_d;
  logic [7:0] pkt_len_q, pkt_len_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_last_q, rd_last_d;

  logic       err_len_q, err_len_d;
  logic       err_chk_q, err_chk_d;
  logic       err_timeout_q, err_timeout_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Payload buffer: contents are don't-care after reset, so it has no reset.
  logic [7:0] pkt_buf [MAX_LEN];
  logic       buf_we;

  logic       in_frame;
  logic       tmo_expire;
  logic [7:0] rd_idx_nxt;
  logic       len_ok;

  assign in_frame   = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  // A byte in the same cycle as expiry wins, so expiry requires no strobe.
  assign tmo_expire = in_frame && !rx_done_tick && s_tick && (tmo_q == TmoLast);
  assign rd_idx_nxt = rd_idx_q + 8'd1;
  assign len_ok     = (rx_data != 8'd0) && (rx_data <= MaxLenB);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    chk_d         = chk_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    tmo_d         = tmo_q;
    pkt_valid_d   = pkt_valid_q;
    pkt_len_d     = pkt_len_q;
    rd_data_d     = rd_data_q;
    rd_last_d     = rd_last_q;
    err_len_d     = 1'b0;
    err_chk_d     = 1'b0;
    err_timeout_d = 1'b0;
    drop_cnt_d    = drop_cnt_q;
    buf_we        = 1'b0;

    // Inter-byte timer: idle outside a frame, restarted by every byte.
    if (!in_frame || rx_done_tick) begin
      tmo_d = '0;
    end else if (s_tick) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      StHunt: begin
        if (rx_done_tick && (rx_data == SYNC_BYTE)) begin
          state_d = StLen;
        end
      end

      StLen: begin
        if (rx_done_tick) begin
          if (len_ok) begin
            len_d    = rx_data;
            chk_d    = rx_data;
            wr_idx_d = 8'd0;
            state_d  = StPayload;
          end else begin
            err_len_d = 1'b1;
            state_d   = StHunt;
          end
        end
      end

      StPayload: begin
        if (rx_done_tick) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_data;
          if (wr_idx_q == (len_q - 8'd1)) begin
            state_d = StChk;
          end else begin
            wr_idx_d = wr_idx_q + 8'd1;
          end
        end
      end

      StChk: begin
        if (rx_done_tick) begin
          if (rx_data == chk_q) begin
            // Preload the first byte so rd_data is valid with pkt_valid.
            state_d     = StHold;
            pkt_valid_d = 1'b1;
            pkt_len_d   = len_q;
            rd_idx_d    = 8'd0;
            rd_data_d   = pkt_buf[0];
            rd_last_d   = (len_q == 8'd1);
          end else begin
            err_chk_d = 1'b1;
            state_d   = StHunt;
          end
        end
      end

      StHold: begin
        // Bytes arriving while a packet is held are lost, even on the
        // cycle the packet is released.
        if (rx_done_tick && (drop_cnt_q != 8'hFF)) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (rd.rd_en) begin
          if (rd_last_q) begin
            pkt_valid_d = 1'b0;
            rd_last_d   = 1'b0;
            state_d     = StHunt;
          end else begin
            rd_idx_d  = rd_idx_nxt;
            rd_data_d = pkt_buf[rd_idx_nxt[IdxW-1:0]];
            rd_last_d = (rd_idx_nxt == (pkt_len_q - 8'd1));
          end
        end
      end

      default: begin
        state_d = StHunt;
      end
    endcase

    if (tmo_expire) begin
      err_timeout_d = 1'b1;
      state_d       = StHunt;
      tmo_d         = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StHunt;
      len_q         <= 8'd0;
      chk_q         <= 8'd0;
      wr_idx_q      <= 8'd0;
      rd_idx_q      <= 8'd0;
      tmo_q         <= '0;
      pkt_valid_q   <= 1'b0;
      pkt_len_q     <= 8'd0;
      rd_data_q     <= 8'd0;
      rd_last_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      drop_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      chk_q         <= chk_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      tmo_q         <= tmo_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_len_q     <= pkt_len_d;
      rd_data_q     <= rd_data_d;
      rd_last_q     <= rd_last_d;
      err_len_q     <= err_len_d;
      err_chk_q     <= err_chk_d;
      err_timeout_q <= err_timeout_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      pkt_buf[wr_idx_q[IdxW-1:0]] <= rx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd.pkt_valid = pkt_valid_q;
  assign rd.pkt_len   = pkt_len_q;
  assign rd.rd_data   = rd_data_q;
  assign rd.rd_last   = rd_last_q;
  assign err_len      = err_len_q;
  assign err_chk      = err_chk_q;
  assign err_timeout  = err_timeout_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_pkt_ctrl
// Directed bench for uart_rx_pkt_ctrl: good frames, checksum/length errors,
// timeout with and without a coincident byte, overrun saturation, simultaneous
// final read and byte arrival, and asynchronous reset mid-frame / mid-hold.
// Inputs are driven on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_uart_rx_pkt_ctrl;

  logic       clk          = 1'b0;
  logic       reset        = 1'b1;
  logic       s_tick       = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data      = 8'h00;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;
  logic [7:0] drop_cnt;

  uart_rx_pkt_ctrl_if rd_if ();

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE     (8'hA5),
    .MAX_LEN       (16),
    .TIMEOUT_TICKS (320)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rd           (rd_if.master),
    .err_len      (err_len),
    .err_chk      (err_chk),
    .err_timeout  (err_timeout),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Count high cycles of each error pulse.
  int cnt_len = 0;
  int cnt_chk = 0;
  int cnt_tmo = 0;

  always @(posedge clk) begin
    if (err_len)     cnt_len <= cnt_len + 1;
    if (err_chk)     cnt_chk <= cnt_chk + 1;
    if (err_timeout) cnt_tmo <= cnt_tmo + 1;
  end

  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic send_byte(input logic [7:0] b, input logic with_tick = 1'b0);
    rx_data      = b;
    rx_done_tick = 1'b1;
    s_tick       = with_tick;
    @(negedge clk);
    rx_done_tick = 1'b0;
    s_tick       = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {rd_if.pkt_valid, rd_if.pkt_len, rd_if.rd_data, rd_if.rd_last,
                err_len, err_chk, err_timeout, drop_cnt}, 32'd0);
  endtask

  // Reads the held packet with rd_en held high, expecting exp_q.
  task automatic read_pkt(input string tag);
    rd_if.rd_en = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check({tag, "_valid"}, {31'd0, rd_if.pkt_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, rd_if.rd_data}, {24'd0, exp_q[i]});
      check({tag, "_last"}, {31'd0, rd_if.rd_last}, (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    rd_if.rd_en = 1'b0;
    check({tag, "_released"}, {31'd0, rd_if.pkt_valid}, 32'd0);
  endtask

  initial begin
    rd_if.rd_en = 1'b0;
    #1;
    check_zero("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Good frame
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    check("good_valid", {31'd0, rd_if.pkt_valid}, 32'd1);
    check("good_len", {24'd0, rd_if.pkt_len}, 32'd3);
    exp_q = '{8'h11, 8'h22, 8'h33};
    read_pkt("good");
    settle();
    check("good_no_err", cnt_len + cnt_chk + cnt_tmo, 32'd0);

    // Bad checksum, then a good frame
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h04);
    check("badchk_pulse", {31'd0, err_chk}, 32'd1);
    check("badchk_valid", {31'd0, rd_if.pkt_valid}, 32'd0);
    @(negedge clk);
    check("badchk_pulse_end", {31'd0, err_chk}, 32'd0);
    settle();
    check("badchk_cnt", cnt_chk, 32'd1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'h20); send_byte(8'h32);
    check("after_bad_len", {24'd0, rd_if.pkt_len}, 32'd2);
    exp_q = '{8'h10, 8'h20};
    read_pkt("after_bad");

    // Length errors, then garbage before a 1-byte frame
    send_byte(8'hA5); send_byte(8'h00);
    check("len0_pulse", {31'd0, err_len}, 32'd1);
    send_byte(8'hA5); send_byte(8'h11);
    check("len17_pulse", {31'd0, err_len}, 32'd1);
    settle();
    check("len_cnt", cnt_len, 32'd2);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check("garbage_len", {24'd0, rd_if.pkt_len}, 32'd1);
    exp_q = '{8'h7E};
    read_pkt("garbage");
    settle();
    check("garbage_no_err", cnt_len * 100 + cnt_chk * 10 + cnt_tmo, 32'd210);

    // Timeout expiry
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    ticks(319);
    settle();
    check("tmo_319", cnt_tmo, 32'd0);
    ticks(1);
    settle();
    check("tmo_320", cnt_tmo, 32'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check("tmo_hunt_valid", {31'd0, rd_if.pkt_valid}, 32'd1);
    exp_q = '{8'h7E};
    read_pkt("tmo_hunt");

    // Byte on the expiring tick wins
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    ticks(319);
    send_byte(8'h22, 1'b1);
    send_byte(8'h31);
    check("tmo_race_valid", {31'd0, rd_if.pkt_valid}, 32'd1);
    settle();
    check("tmo_race_cnt", cnt_tmo, 32'd1);
    exp_q = '{8'h11, 8'h22};
    read_pkt("tmo_race");

    // Overrun while holding
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    for (int i = 0; i < 200; i++) send_byte(8'(i));
    check("drop_200", {24'd0, drop_cnt}, 32'd200);
    for (int i = 0; i < 100; i++) send_byte(8'hA5);
    check("drop_sat", {24'd0, drop_cnt}, 32'd255);
    exp_q = '{8'h11, 8'h22, 8'h33};
    read_pkt("overrun");

    // Async reset mid-payload
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    #2 reset = 1'b1;
    #1 check_zero("rst_payload");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Async reset while holding
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    check("pre_rst_valid", {31'd0, rd_if.pkt_valid}, 32'd1);
    #2 reset = 1'b1;
    #1 check_zero("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'h20); send_byte(8'h32);
    exp_q = '{8'h10, 8'h20};
    read_pkt("post_rst");

    // Final rd_en together with a sync byte: byte is dropped, not a sync
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    rd_if.rd_en  = 1'b1;
    rx_data      = 8'hA5;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rd_if.rd_en  = 1'b0;
    rx_done_tick = 1'b0;
    check("sim_released", {31'd0, rd_if.pkt_valid}, 32'd0);
    check("sim_drop", {24'd0, drop_cnt}, 32'd1);
    send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    check("sim_not_sync", {31'd0, rd_if.pkt_valid}, 32'd0);
    // rd_en with no packet held must be ignored
    rd_if.rd_en = 1'b1;
    repeat (3) @(negedge clk);
    rd_if.rd_en = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h13);
    exp_q = '{8'h44, 8'h55};
    read_pkt("final");
    settle();
    check("final_err_cnt", cnt_len * 100 + cnt_chk * 10 + cnt_tmo, 32'd211);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
Packet controller that sits directly behind the UART receiver and consumes its byte stream (rx_done_tick / dout).
- Hunts for a sync byte, then sequences length, payload and checksum fields, storing the payload in an internal buffer.
- Presents each checked packet to a downstream consumer through a read handshake.
- Flags length, checksum, inter-byte timeout and overrun errors.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes (1..255); sets buffer depth.
- TIMEOUT_TICKS, 320, s_tick count without a new byte mid-frame before abort (two 10-bit character times at 16x oversampling).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_tick  in  1  16x baud sample tick (same tick that drives the receiver)
- rx_done_tick  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- pkt_valid  out  1  checked packet held; rd_data valid
- pkt_len  out  8  payload length of held packet
- rd_data  out  8  payload byte at current read index
- rd_last  out  1  rd_data is final payload byte
- rd_en  in  1  consumer accepts rd_data this cycle
- err_len  out  1  one-cycle pulse: LEN==0 or LEN>MAX_LEN
- err_chk  out  1  one-cycle pulse: checksum mismatch
- err_timeout  out  1  one-cycle pulse: inter-byte timeout
- drop_cnt  out  8  saturating count of bytes dropped while holding a packet

Behaviour:
- Reset (async): state HUNT; pkt_valid=0; pkt_len=0; rd_data=0; rd_last=0; all err_* = 0; drop_cnt=0; internal indices, checksum and timeout counter = 0. Buffer contents are don't-care.
- Checksum: 8-bit XOR of LEN and every payload byte. The CHK byte must equal it.
- States and transitions (all on rx_done_tick unless noted):
  - HUNT: rx_data==SYNC_BYTE -> LEN. Any other byte is ignored silently.
  - LEN:
    - 1<=rx_data<=MAX_LEN -> latch length; chk=rx_data; wr_idx=0; go to PAYLOAD.
    - Otherwise -> err_len pulse, go to HUNT.
  - PAYLOAD: write rx_data to buf[wr_idx]; chk^=rx_data. When wr_idx==len-1 -> CHK; else wr_idx++.
  - CHK:
    - rx_data==chk -> HOLD. Next cycle: pkt_valid=1, pkt_len=len, rd_idx=0.
    - Mismatch -> err_chk pulse, go to HUNT. Buffer contents are discarded.
  - HOLD:
    - pkt_valid=1. rd_data=buf[rd_idx] (registered; valid whenever pkt_valid=1). rd_last=(rd_idx==pkt_len-1).
    - rd_en: rd_idx++ and rd_data updates next cycle.
    - rd_en while rd_last=1: next cycle pkt_valid=0, rd_last=0, go to HUNT.
    - rx_done_tick in HOLD: byte dropped; drop_cnt++ (saturates at 255, never wraps).
- Timeout (LEN, PAYLOAD, CHK only):
  - Counter clears on entry to these states and on every rx_done_tick; increments on s_tick.
  - Reaching TIMEOUT_TICKS -> err_timeout pulse, go to HUNT.
  - Counter is held at 0 in HUNT and HOLD.
- Simultaneous events:
  - rx_done_tick and timeout expiry in the same cycle: the byte wins (processed, counter cleared, no err_timeout).
  - rx_done_tick in the same cycle as the final rd_en: byte counted as dropped, not used as sync.
  - rd_en while pkt_valid=0: ignored.
- Latency: CHK byte strobe -> pkt_valid high on the next clock edge. rd_en -> next rd_data valid the following cycle.
- Error pulses are exactly one cycle and mutually exclusive.
- Reset mid-frame or mid-HOLD: immediate return to the reset values above. The held packet is lost.

Test Plan:
- Good frame: bytes A5 03 11 22 33 03 -> pkt_valid=1, pkt_len=3. Reads with rd_en held high give rd_data 11, 22, 33; rd_last high only on 33. pkt_valid=0 the cycle after the last rd_en. No err pulses.
- Bad checksum: A5 03 11 22 33 04 -> one err_chk pulse; pkt_valid stays 0. A following good frame is accepted normally.
- Length errors:
  - A5 00 -> err_len pulse.
  - A5 11 with MAX_LEN=16 -> err_len pulse.
  - Garbage 00 FF 5A before A5 01 7E 7F -> no errors; packet len 1, data 7E.
- Timeout: A5 02 11, then 320 s_ticks with no byte -> err_timeout pulse at tick 320, state HUNT. Repeat with a byte arriving on tick 320 itself -> no err_timeout.
- Overrun: hold a good packet without rd_en and send 300 bytes -> drop_cnt saturates at 255; held data unchanged on readout.
- Async reset asserted mid-PAYLOAD and again in HOLD -> all outputs zero immediately. The next good frame is received correctly.
